// File: rtl/bus_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and
// default bus/transfer geometry.
package bus_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_COUNT_WIDTH    = 16;
  localparam int DEF_ADDR_STEP      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_REQ  = 3'd1,
    READ_WAIT = 3'd2,
    WRITE     = 3'd3,
    FINISH    = 3'd4
  } copy_state_e;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter for the read-wait window; expired marks the last cycle a
// response may still arrive before the engine gives up.
module timeout_counter
  import bus_pkg::*;
#(
  parameter int Limit = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;

  assign expired = (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy: one read, wait for data, one write, repeat until
// the requested count is exhausted or a read response times out.
module mem_copy_engine
  import bus_pkg::*;
#(
  parameter int AddrWidth     = DEF_ADDR_WIDTH,
  parameter int DataWidth     = DEF_DATA_WIDTH,
  parameter int CountWidth    = DEF_COUNT_WIDTH,
  parameter int AddrStep      = DEF_ADDR_STEP,
  parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AddrWidth-1:0]   src_addr,
  input  logic [AddrWidth-1:0]   dst_addr,
  input  logic [CountWidth-1:0]  word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [AddrWidth-1:0]   addr,
  output logic                   read_req,
  input  logic [DataWidth-1:0]   read_data,
  input  logic                   read_data_valid,
  output logic                   write_req,
  output logic [DataWidth-1:0]   write_data,
  output logic [DataWidth/8-1:0] byte_enable
);

  copy_state_e           state_q, state_d;
  logic [AddrWidth-1:0]  src_q, src_d, dst_q, dst_d;
  logic [CountWidth-1:0] rem_q, rem_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  err_q, err_d;
  logic                  tmo_expired;

  timeout_counter #(.Limit(TimeoutCycles)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != READ_WAIT),
    .enable  ((state_q == READ_WAIT) && !read_data_valid),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = word_count;
          err_d   = 1'b0;
          state_d = (word_count != '0) ? READ_REQ : FINISH;
        end
      end
      READ_REQ: state_d = READ_WAIT;
      READ_WAIT: begin
        // A response on the final allowed cycle still wins over the timeout.
        if (read_data_valid) begin
          data_d  = read_data;
          state_d = WRITE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      WRITE: begin
        src_d   = src_q + AddrWidth'(AddrStep);
        dst_d   = dst_q + AddrWidth'(AddrStep);
        rem_d   = rem_q - CountWidth'(1);
        state_d = (rem_q == CountWidth'(1)) ? FINISH : READ_REQ;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FINISH);
    error       = err_q;
    read_req    = (state_q == READ_REQ);
    write_req   = (state_q == WRITE);
    addr        = '0;
    write_data  = '0;
    byte_enable = '0;
    if (state_q == READ_REQ) begin
      addr = src_q;
    end else if (state_q == WRITE) begin
      addr        = dst_q;
      write_data  = data_q;
      byte_enable = '1;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine: a transaction-level model predicts the
// bus trace every cycle, plus directed scenarios with hand-computed literals.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, error, read_req, write_req;
  logic [31:0] addr, write_data;
  logic [31:0] read_data = '0;
  logic        read_data_valid = 1'b0;
  logic [3:0]  byte_enable;

  mem_copy_engine dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .addr            (addr),
    .read_req        (read_req),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .write_req       (write_req),
    .write_data      (write_data),
    .byte_enable     (byte_enable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        error;
    logic        rreq;
    logic        wreq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vec_t        exp_q[$];
  int          lat_q[$];
  int          plan[$];
  logic        model_err = 1'b0;
  logic        last_err = 1'b0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] wd_log[$];
  int          done_log[$];
  int          busy_cnt = 0;
  int          start_cyc = 0;
  int          pend = 0;
  logic [31:0] raddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory contents seen by the follower: a fixed scramble of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic b, input logic d, input logic e, input logic rr,
                              input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be);
    vec_t v;
    v = {b, d, e, rr, wr, a, wd, be};
    return v;
  endfunction

  // Expected cycle-by-cycle trace of one accepted copy, starting with the start cycle.
  task automatic build(input logic [31:0] s, input logic [31:0] d, input int n);
    bit          to;
    int          lat;
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    to = 1'b0;
    exp_q.push_back(mk(0, 0, model_err, 0, 0, '0, '0, '0));
    for (int i = 0; i < n && !to; i++) begin
      a = s + 32'(i) * 32'd4;
      b = d + 32'(i) * 32'd4;
      exp_q.push_back(mk(1, 0, 0, 1, 0, a, '0, '0));
      lat = plan[i];
      lat_q.push_back(lat);
      w = (lat > 16) ? 16 : lat;
      for (int k = 0; k < w; k++) exp_q.push_back(mk(1, 0, 0, 0, 0, '0, '0, '0));
      if (lat > 16) to = 1'b1;
      else exp_q.push_back(mk(1, 0, 0, 0, 1, b, rom(a), 4'hF));
    end
    exp_q.push_back(mk(1, 1, to, 0, 0, '0, '0, '0));
    model_err = to;
  endtask

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_err = e.error;
    end else begin
      e = mk(0, 0, last_err, 0, 0, '0, '0, '0);
    end
    a = {busy, done, error, read_req, write_req, addr, write_data, byte_enable};
    check("cycle_trace", a === e, 128'(a), 128'(e));
  end

  always @(negedge clk) begin
    if (read_req) rd_log.push_back(addr);
    if (write_req) begin
      wr_log.push_back(addr);
      wd_log.push_back(write_data);
    end
    if (done) done_log.push_back(cyc);
    if (busy) busy_cnt++;
  end

  // Follower: answers each read after the planned latency, with stray valids elsewhere.
  always @(posedge clk) begin
    #1;
    if (!busy) pend = 0;
    if (read_req) begin
      pend = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      raddr = addr;
      read_data_valid = ($urandom_range(0, 3) == 0);
      read_data = $urandom;
    end else if (pend > 0) begin
      pend--;
      read_data_valid = (pend == 0);
      read_data = (pend == 0) ? rom(raddr) : $urandom;
    end else begin
      read_data_valid = ($urandom_range(0, 3) == 0);
      read_data = $urandom;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
    done_log.delete();
    busy_cnt = 0;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit noise);
    int guard;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    word_count = 16'(n);
    build(s, d, n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    word_count = 16'($urandom);
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      start = noise && ($urandom_range(0, 2) == 0);
      if (start) begin
        src_addr = $urandom;
        dst_addr = $urandom;
        word_count = 16'($urandom_range(0, 8));
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    check("copy_completes", guard < 3000, 128'(guard), 128'(0));
    if (guard >= 3000) exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, error, read_req, write_req, addr, write_data,
          byte_enable} === 73'd0,
          128'({busy, done, error, read_req, write_req, addr, write_data, byte_enable}), 0);
    reset = 1'b0;

    // Three words at latency 1.
    plan = '{1, 1, 1};
    run_copy(32'h2000_0000, 32'h1000_0000, 3, 1'b0);
    check("basic_reads", rd_log.size() == 3 && rd_log[0] == 32'h2000_0000 &&
          rd_log[1] == 32'h2000_0004 && rd_log[2] == 32'h2000_0008,
          128'(rd_log.size()), 128'(3));
    check("basic_waddr", wr_log.size() == 3 && wr_log[0] == 32'h1000_0000 &&
          wr_log[1] == 32'h1000_0004 && wr_log[2] == 32'h1000_0008,
          128'(wr_log.size()), 128'(3));
    check("basic_wdata", wd_log.size() == 3 && wd_log[0] == 32'h5A5A_E3C3 &&
          wd_log[1] == 32'h5A5E_E3C3 && wd_log[2] == 32'h5A52_E3C3,
          128'(wd_log.size() > 0 ? wd_log[0] : 0), 128'(32'h5A5A_E3C3));
    check("basic_done_lat", done_log.size() == 1 && done_log[0] - start_cyc == 10,
          128'(done_log.size() > 0 ? done_log[0] - start_cyc : -1), 128'(10));
    check("basic_error", error == 1'b0, 128'(error), 128'(0));

    // Zero-length copy.
    plan = {};
    run_copy(32'h0000_1000, 32'h0000_2000, 0, 1'b0);
    check("zero_no_bus", rd_log.size() == 0 && wr_log.size() == 0,
          128'(rd_log.size() + wr_log.size()), 128'(0));
    check("zero_done_lat", done_log.size() == 1 && done_log[0] - start_cyc == 1,
          128'(done_log.size() > 0 ? done_log[0] - start_cyc : -1), 128'(1));
    check("zero_busy_len", busy_cnt == 1, 128'(busy_cnt), 128'(1));

    // Follower never answers.
    plan = '{1000, 1000};
    run_copy(32'h0000_4000, 32'h0000_8000, 2, 1'b0);
    check("tmo_writes", wr_log.size() == 0, 128'(wr_log.size()), 128'(0));
    check("tmo_reads", rd_log.size() == 1, 128'(rd_log.size()), 128'(1));
    check("tmo_done_lat", done_log.size() == 1 && done_log[0] - start_cyc == 18,
          128'(done_log.size() > 0 ? done_log[0] - start_cyc : -1), 128'(18));
    check("tmo_error_sticky", error == 1'b1, 128'(error), 128'(1));

    // Start pulses while busy must be ignored.
    plan = '{1, 2, 1, 3};
    run_copy(32'h0000_0100, 32'h0000_0200, 4, 1'b1);
    check("noise_writes", wr_log.size() == 4, 128'(wr_log.size()), 128'(4));
    check("noise_dones", done_log.size() == 1, 128'(done_log.size()), 128'(1));
    check("error_cleared", error == 1'b0, 128'(error), 128'(0));

    // Source address wraps through zero.
    plan = '{1, 1};
    run_copy(32'hFFFF_FFFC, 32'h0000_0040, 2, 1'b0);
    check("wrap_read0", rd_log.size() == 2 && rd_log[0] == 32'hFFFF_FFFC,
          128'(rd_log.size() > 0 ? rd_log[0] : 0), 128'(32'hFFFF_FFFC));
    check("wrap_read1", rd_log.size() == 2 && rd_log[1] == 32'h0000_0000,
          128'(rd_log.size() > 1 ? rd_log[1] : 32'hDEAD), 128'(0));

    // Reset during the second read-wait of a five-word copy.
    plan = '{3, 3, 3, 3, 3};
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    src_addr = 32'h0000_3000;
    dst_addr = 32'h0000_5000;
    word_count = 16'd5;
    build(32'h0000_3000, 32'h0000_5000, 5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("pre_reset_wait", busy && !read_req && !write_req && wr_log.size() == 1,
          128'({busy, read_req, write_req}), 128'(3'b100));
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    model_err = 1'b0;
    last_err = 1'b0;
    #1;
    check("reset_abort_outs", {busy, done, error, read_req, write_req, addr, write_data,
          byte_enable} === 73'd0,
          128'({busy, done, error, read_req, write_req, addr, write_data, byte_enable}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_no_done", done_log.size() == 0, 128'(done_log.size()), 128'(0));
    plan = '{1};
    run_copy(32'h0000_0010, 32'h0000_0020, 1, 1'b0);
    check("post_reset_write", wr_log.size() == 1 && wr_log[0] == 32'h0000_0020,
          128'(wr_log.size() > 0 ? wr_log[0] : 0), 128'(32'h20));
    check("post_reset_done", done_log.size() == 1 && done_log[0] - start_cyc == 4,
          128'(done_log.size() > 0 ? done_log[0] - start_cyc : -1), 128'(4));

    // Randomized copies checked by the per-cycle trace model.
    for (int t = 0; t < 40; t++) begin
      int          n;
      logic [31:0] s;
      int          lats[8];
      lats = '{1, 1, 2, 3, 5, 16, 17, 1000};
      n = $urandom_range(0, 5);
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
      plan = {};
      for (int i = 0; i < n; i++) plan.push_back(lats[$urandom_range(0, 7)]);
      run_copy(s, $urandom & ~32'h3, n, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
